// File: rtl/pyramid_ctrl_if.sv
// rtl/pyramid_ctrl_if.sv - control/status bundle between the pyramid sequencer and its users
interface pyramid_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             enable;
    logic             start;
    logic [WIDTH-1:0] top;
    logic             abort;
    logic             busy;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] ramp_top;
    logic             pulse1;
    logic             pulse2;

    modport master (
        output enable, start, top, abort,
        input  busy, out, ramp_top, pulse1, pulse2
    );

    modport slave (
        input  enable, start, top, abort,
        output busy, out, ramp_top, pulse1, pulse2
    );
endinterface

// File: rtl/pyramid_ctrl.sv
// rtl/pyramid_ctrl.sv - pyramid count sequencer (ramps 0..N, 0..N-1, ... 0), falling-edge clocked
// Optional back-to-back reload without an IDLE cycle: define PYRAMID_CTRL_RELOAD_EN.
module pyramid_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic          up_i,
    input  logic          reset_i,
    pyramid_ctrl_if.slave bus
);
    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] ramp_top_q, ramp_top_d;
    logic             busy_q, busy_d;
    logic             pulse1_q, pulse1_d;
    logic             pulse2_q, pulse2_d;

    always_ff @(negedge up_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            out_q      <= '0;
            ramp_top_q <= '0;
            busy_q     <= 1'b0;
            pulse1_q   <= 1'b0;
            pulse2_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            ramp_top_q <= ramp_top_d;
            busy_q     <= busy_d;
            pulse1_q   <= pulse1_d;
            pulse2_q   <= pulse2_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        out_d      = out_q;
        ramp_top_d = ramp_top_q;
        busy_d     = busy_q;
        pulse1_d   = 1'b0;
        pulse2_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start && bus.enable && !bus.abort) begin
                    state_d    = RUN;
                    ramp_top_d = bus.top;
                    out_d      = '0;
                    busy_d     = 1'b1;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d    = IDLE;
                    out_d      = '0;
                    ramp_top_d = '0;
                    busy_d     = 1'b0;
                end else if (bus.enable) begin
                    if (out_q < ramp_top_q) begin
                        out_d = out_q + WIDTH'(1);
                    end else if (ramp_top_q != '0) begin
                        pulse1_d   = 1'b1;
                        out_d      = '0;
                        ramp_top_d = ramp_top_q - WIDTH'(1);
                    end else begin
                        pulse1_d = 1'b1;
                        pulse2_d = 1'b1;
`ifdef PYRAMID_CTRL_RELOAD_EN
                        // abort is already known low here, so a held start chains straight in
                        if (bus.start) begin
                            ramp_top_d = bus.top;
                            out_d      = '0;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end
`else
                        busy_d  = 1'b0;
                        state_d = IDLE;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy     = busy_q;
    assign bus.out      = out_q;
    assign bus.ramp_top = ramp_top_q;
    assign bus.pulse1   = pulse1_q;
    assign bus.pulse2   = pulse2_q;
endmodule

// File: tb/tb_pyramid_ctrl.sv
// tb/tb_pyramid_ctrl.sv - scoreboard bench for pyramid_ctrl
module tb_pyramid_ctrl;
    localparam int WIDTH = 4;
`ifdef PYRAMID_CTRL_RELOAD_EN
    localparam bit RELOAD = 1'b1;
`else
    localparam bit RELOAD = 1'b0;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] out;
        logic [WIDTH-1:0] rt;
        logic             busy;
        logic             p1;
        logic             p2;
    } exp_t;

    logic up = 1'b0;
    logic reset = 1'b1;
    pyramid_ctrl_if #(.WIDTH(WIDTH)) bus ();

    pyramid_ctrl #(.WIDTH(WIDTH)) dut (
        .up_i    (up),
        .reset_i (reset),
        .bus     (bus.slave)
    );

    always #5 up = ~up;

    exp_t   sb[$];
    exp_t   last_e;
    int     n_checks = 0;
    int     n_errors = 0;
    int     busy_cnt, p1_cnt, p2_cnt;
    time    p2_times[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input int o, input int r, input bit b, input bit p1, input bit p2);
        exp_t e;
        e.out  = WIDTH'(o);
        e.rt   = WIDTH'(r);
        e.busy = b;
        e.p1   = p1;
        e.p2   = p2;
        return e;
    endfunction

    // chain: this pyramid reloads straight off the previous one's final edge
    task automatic push_pyramid(input int n, input bit chain, input bit fin);
        if (chain) begin
            void'(sb.pop_back());
            sb.push_back(mk(0, n, 1'b1, 1'b1, 1'b1));
        end
        for (int r = n; r >= 0; r--) begin
            for (int v = 0; v <= r; v++) begin
                if (!(chain && r == n && v == 0))
                    sb.push_back(mk(v, r, 1'b1, (v == 0 && r != n), 1'b0));
            end
        end
        if (fin) sb.push_back(mk(0, 0, 1'b0, 1'b1, 1'b1));
    endtask

    task automatic sample_counts();
        if (bus.busy === 1'b1) busy_cnt++;
        if (bus.pulse1 === 1'b1) p1_cnt++;
        if (bus.pulse2 === 1'b1) begin
            p2_cnt++;
            p2_times.push_back($time);
        end
    endtask

    task automatic pop_check(input string tag);
        @(posedge up);
        sample_counts();
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            last_e = sb.pop_front();
            check({tag, ".out"}, 32'(bus.out), 32'(last_e.out));
            check({tag, ".ramp_top"}, 32'(bus.ramp_top), 32'(last_e.rt));
            check({tag, ".busy"}, 32'(bus.busy), 32'(last_e.busy));
            check({tag, ".pulse1"}, 32'(bus.pulse1), 32'(last_e.p1));
            check({tag, ".pulse2"}, 32'(bus.pulse2), 32'(last_e.p2));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".busy"}, 32'(bus.busy), 32'd0);
        check({tag, ".out"}, 32'(bus.out), 32'd0);
        check({tag, ".ramp_top"}, 32'(bus.ramp_top), 32'd0);
        check({tag, ".pulse1"}, 32'(bus.pulse1), 32'd0);
        check({tag, ".pulse2"}, 32'(bus.pulse2), 32'd0);
    endtask

    task automatic clear_counts();
        busy_cnt = 0;
        p1_cnt   = 0;
        p2_cnt   = 0;
        p2_times.delete();
    endtask

    task automatic begin_run(input string tag, input int n);
        bus.start = 1'b1;
        bus.top   = WIDTH'(n);
        push_pyramid(n, 1'b0, 1'b1);
        pop_check(tag);
        bus.start = 1'b0;
    endtask

    task automatic drain(input string tag);
        while (sb.size() > 0) pop_check(tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.enable = 1'b1;
        bus.start  = 1'b0;
        bus.abort  = 1'b0;
        bus.top    = '0;
        repeat (3) @(posedge up);
        check_all_zero("reset");
        reset = 1'b0;
        @(posedge up);

        // basic N=3 pyramid
        clear_counts();
        begin_run("n3", 3);
        drain("n3");
        check("n3.busy_cycles", busy_cnt, 10);
        check("n3.pulse1_count", p1_cnt, 4);
        check("n3.pulse2_count", p2_cnt, 1);

        // degenerate single-cycle pyramid
        clear_counts();
        begin_run("n0", 0);
        drain("n0");
        check("n0.busy_cycles", busy_cnt, 1);
        check("n0.pulse2_count", p2_cnt, 1);

        // freeze with enable low mid-ramp
        clear_counts();
        begin_run("n15", 15);
        repeat (19) pop_check("n15");
        bus.enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge up);
            sample_counts();
            check("freeze.out", 32'(bus.out), 32'(last_e.out));
            check("freeze.ramp_top", 32'(bus.ramp_top), 32'(last_e.rt));
            check("freeze.busy", 32'(bus.busy), 32'd1);
            check("freeze.pulses", 32'({bus.pulse1, bus.pulse2}), 32'd0);
        end
        bus.enable = 1'b1;
        drain("n15");
        check("n15.busy_cycles", busy_cnt, 141);
        check("n15.pulse1_count", p1_cnt, 16);

        // abort at out=2 of second ramp (6 + 3 entries in)
        clear_counts();
        begin_run("abort", 5);
        repeat (8) pop_check("abort");
        check("abort.pre_out", 32'(last_e.out), 32'(bus.out));
        bus.abort = 1'b1;
        @(posedge up);
        sample_counts();
        check_all_zero("abort.after");
        sb.delete();
        bus.start = 1'b1;
        bus.top   = 4'd7;
        @(posedge up);
        sample_counts();
        check_all_zero("start_abort_idle");
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("abort.pulse2_count", p2_cnt, 0);
        @(posedge up);

        // start while busy is ignored, then reset mid-run
        clear_counts();
        begin_run("busy_start", 4);
        repeat (2) pop_check("busy_start");
        bus.start = 1'b1;
        bus.top   = 4'd9;
        pop_check("busy_start");
        bus.start = 1'b0;
        repeat (5) pop_check("busy_start");
        reset = 1'b1;
        @(posedge up);
        sample_counts();
        check_all_zero("reset_mid");
        sb.delete();
        reset = 1'b0;
        check("reset_mid.pulse2_count", p2_cnt, 0);
        @(posedge up);

        // start held high: back-to-back pyramids
        clear_counts();
        bus.start = 1'b1;
        bus.top   = 4'd2;
        push_pyramid(2, 1'b0, 1'b1);
        push_pyramid(2, RELOAD, 1'b1);
        push_pyramid(2, RELOAD, 1'b0);
        drain("held");
        bus.start = 1'b0;
        check("held.pulse2_count", p2_cnt, 2);
        if (p2_times.size() == 2)
            check("held.pulse2_period", 32'((p2_times[1] - p2_times[0]) / 10), RELOAD ? 32'd6 : 32'd7);
        reset = 1'b1;
        @(posedge up);
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/pyramid_ctrl.md
# pyramid_ctrl

Sequencer that drives a pyramid count pattern. On a start request it latches a ceiling N and emits a series of ramps:
- the first ramp counts 0..N, then 0..N-1, and so on, down to a final ramp of 0;
- a strobe marks the end of each ramp, and a second strobe marks the end of the whole pyramid.

It owns the start/busy handshake, pause via `enable`, and abort, and sits between the control logic and the pulse/count consumers.

## Interface
Parameters:
- `WIDTH`, 4, width of count and ceiling.

Ports:
- `up`  in  1  clock; all flops update on the falling edge of `up`.
- `reset`  in  1  synchronous, active-high; sampled on the active edge of `up`.
- `enable`  in  1  high = advance; low = freeze all state.
- `start`  in  1  request level, sampled only in IDLE.
- `top`  in  WIDTH  ceiling N, latched when `start` is accepted.
- `abort`  in  1  cancel the run in progress.
- `busy`  out  1  high while a pyramid is running.
- `out`  out  WIDTH  current count value.
- `ramp_top`  out  WIDTH  ceiling of the current ramp.
- `pulse1`  out  1  one-cycle strobe at the end of every ramp.
- `pulse2`  out  1  one-cycle strobe at the end of the final ramp.

## Operation
Reset values: state IDLE; `busy`, `out`, `ramp_top`, `pulse1`, `pulse2` all 0.

States:
- IDLE:
  - `out`=0, `busy`=0.
  - `start`=1 && `enable`=1 && `abort`=0 → RUN, `ramp_top`←`top`, `out`←0, `busy`←1.
- RUN, per active edge with `enable`=1 (`pulse1`/`pulse2` default to 0 unless set below):
  - `out` < `ramp_top`: `out`←`out`+1.
  - `out` == `ramp_top` && `ramp_top` ≠ 0: `pulse1`←1, `out`←0, `ramp_top`←`ramp_top`−1.
  - `out` == 0 && `ramp_top` == 0 (final ramp): `pulse1`←1, `pulse2`←1, `busy`←0, state←IDLE.

Rules:
- Arithmetic is unsigned WIDTH-bit; `out` never exceeds `ramp_top`, and `ramp_top` never decrements below 0, so there is no wrap-around.
- `top`=0 gives a single one-cycle ramp: `pulse1` and `pulse2` fire together.
- `enable`=0: `out`, `ramp_top`, `busy` and state hold; `pulse1`/`pulse2` are driven 0; `start` is ignored.
- `abort`=1 in RUN, regardless of `enable` → IDLE next edge: `out`=0, `ramp_top`=0, `busy`=0, no pulses.
- Priority: `reset` > `abort` > `enable` gating > normal sequencing.
- `start` while `busy`=1 is ignored; `top` changes while busy have no effect.
- `start` and `abort` in the same IDLE cycle: abort wins and the block stays IDLE.
- `reset` mid-run: all outputs are 0 on the next edge and no pulses are emitted.

## Timing
- Start latency: `start` sampled at edge t → `busy`=1, `out`=0, `ramp_top`=N after edge t.
- Run length: `busy` stays high for (N+1)(N+2)/2 enabled cycles, plus any cycles with `enable` low.
- `pulse1`:
  - Non-final ramps: asserted in the cycle where `out` shows 0 of the next ramp.
  - Final ramp: asserted in the first cycle with `busy`=0.
- `pulse2`: coincides with the last `pulse1`.
- Both strobes are registered and last exactly one cycle.
- Back-to-back runs: at least one IDLE cycle between runs, unless the reload feature below is compiled in.

## Configuration
Macro `PYRAMID_CTRL_RELOAD_EN`.

Defined:
- At the final-ramp edge, if `start`=1 and `abort`=0, the block reloads directly:
  - `ramp_top`←`top`, `out`←0;
  - `busy` stays 1 and state stays RUN;
  - `pulse1`/`pulse2` still fire.
- Zero dead cycles between pyramids.

Undefined:
- The block always returns to IDLE for at least one cycle before the next run.

## Test plan
- `top`=3, `start` one cycle, `enable`=1 → `out` sequence 0,1,2,3,0,1,2,0,1,0; `pulse1`×4; `pulse2`×1, coincident with the 4th `pulse1`; `busy` high 10 cycles.
- `top`=0 → `busy` high 1 cycle; `pulse1`=`pulse2`=1 in the same cycle; `out` stays 0.
- `top`=15, drop `enable` for 5 cycles mid-ramp → `out`/`ramp_top` frozen and pulses 0 during the freeze; total `busy` = 136+5 cycles.
- `top`=5, `abort` at `out`=2 of the second ramp → next cycle `busy`=0, `out`=0, `ramp_top`=0, no `pulse2`; `start`+`abort` together in IDLE → stays IDLE.
- `reset` asserted mid-run and `start` pulsed while busy → reset clears all outputs on the next edge; `start` while busy has no effect on `ramp_top`.
- With `PYRAMID_CTRL_RELOAD_EN`, `start` held high, `top`=2 → 6-cycle pyramids back to back, `busy` never drops, `pulse2` every 6 cycles; without the macro, 1 IDLE cycle between runs (7-cycle period).
